snake_grid_builder: RTL and testbench
=====================================

// Module: snake_grid_builder
// PURPOSE
//  Downstream of the snake game-logic block. Snapshots the packed snake body, length index and food position.
//  Scans the segments over several cycles into a 16x16 occupancy bitmap, then double-buffers the result for the display.
//  Provides a registered cell-lookup port for the VGA renderer. Optionally flags head-on-body collision.
// PARAMETERS
//  LANES     4     segments decoded per SCAN cycle (1..16)
//  MAX_SEGS  225   max segments held in the snake vector
//  SNAKE_W   1800  snake vector width (8*MAX_SEGS)
// PORTS
//  slw_clk      in   1        clock
//  reset        in   1        sync, active-high
//  snake        in   SNAKE_W  segment k = snake[8k+7:8k] = {y[3:0],x[3:0]}; k=0 is the tail
//  index        in   11       MSB position of the head segment
//  write_snake  in   1        level; snapshot is allowed while high
//  xfood,yfood  in   4 each   food cell; {yfood,xfood}==8'h00 means no food
//  rd_x,rd_y    in   4 each   display lookup address
//  rd_cell      out  2        00 empty, 01 body, 10 head, 11 food
//  frame_valid  out  1        1-cycle pulse when a new frame is published
//  frame_count  out  16       number of frames published (wraps)
//  seg_count    out  8        segment count of the published frame
//  collision    out  1        published frame has the head on a body cell
// BEHAVIOUR
//  Reset: state IDLE; back and front bitmaps = 0; all outputs = 0. Reset wins over every other event.
//  Reset mid-scan aborts the scan: no frame_valid pulse, front buffer is cleared.
//  FSM IDLE -> SCAN -> IDLE.
//  IDLE, write_snake=1 at edge E0:
//   - latch snake, food and N = min((index+1)>>3, MAX_SEGS), flooring a misaligned index
//   - head = segment N-1; if N=0, head_valid=0
//   - clear back bitmap, ptr=0, go to SCAN
//  SCAN, each edge:
//   - for lanes i<LANES with ptr+i < N-1, set back[{y,x}] of segment ptr+i
//   - ptr += LANES
//   - the head segment is never written as body
//   - when ptr+LANES >= N-1 (or N<=1), this is the final SCAN edge and it also publishes
//  Publish (final SCAN edge):
//   - front <= back incl. this edge's lanes; latch head and food
//   - frame_valid=1 for exactly one cycle; frame_count++; seg_count=N; update collision
//   - state goes to IDLE
//  Latency: publish edge = E0 + max(1, ceil((N-1)/LANES)).
//   - if write_snake stays high, the next capture is on the following edge
//   - frame period = latency + 1 edges
//  rd_cell, registered with 1-cycle latency from front data before the edge:
//   - priority head > body > food > empty
//   - food shown only if nonzero
//   - a read on the publish edge returns the old frame
//  Duplicate segments are idempotent (OR).
//  Coordinates are 4-bit, so no out-of-range cell exists.
// CONFIGURATION
//  SNAKE_SELF_COLLISION_EN defined:
//   - each body lane compares against head; any match in the scan sets collision at publish
//   - collision is cleared for the next frame
//  Not defined: collision tied 0, comparators absent.
// STRUCTURE
//  Package snake_pkg holds:
//   - cell_t (2-bit) and CELL_EMPTY / CELL_BODY / CELL_HEAD / CELL_FOOD
//   - grid_state_t {IDLE, SCAN}
//   - SEG_W=8, GRID_CELLS=256
//  Sub-module snake_seg_decoder, one per lane: (seg[7:0], en) -> 256-bit one-hot OR-mask.
// TESTING
//  1 Reset, then write_snake=1 with segs {1,1},{1,2},{1,3}, index=23, food (3,3):
//    frame_valid after E1; seg_count=3. rd (x1,y1)=01, (2,1)=01, (3,1)=10, (3,3)=11, (0,0)=00.
//  2 10 segments, LANES=4, write_snake held high:
//    frame_valid after E3 (ceil(9/4)), then every 4 edges; frame_count increments by 1 each pulse.
//  3 Head (5,5) duplicated at segment 2:
//    collision=1 with SNAKE_SELF_COLLISION_EN, 0 without; next clean frame gives collision=0.
//  4 Reset asserted at E2 of a 10-segment scan:
//    no frame_valid; rd_cell=00 for all cells; frame_count=0.
//  5 index=1799 gives seg_count=225 and publish after E56.
//    food {0,0} gives rd (0,0)=00 unless a segment occupies (0,0).
//  6 rd on the publish edge returns the previous frame's cell; the next cycle returns the new one.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake occupancy-grid builder.
// Cell encoding, FSM states and a rd_cell priority helper.
package snake_pkg;

  typedef logic [1:0] cell_t;

  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_BODY  = 2'b01;
  localparam cell_t CELL_HEAD  = 2'b10;
  localparam cell_t CELL_FOOD  = 2'b11;

  typedef enum logic {
    IDLE,
    SCAN
  } grid_state_t;

  localparam int SEG_W      = 8;
  localparam int GRID_CELLS = 256;

  // Head wins over body, body over food.
  function automatic cell_t cell_pick(
    input logic head,
    input logic body,
    input logic food
  );
    cell_t c;
    if (head)      c = CELL_HEAD;
    else if (body) c = CELL_BODY;
    else if (food) c = CELL_FOOD;
    else           c = CELL_EMPTY;
    return c;
  endfunction

endpackage

// File: rtl/snake_grid_builder_seg_decoder.sv
// One scan lane: turns a {y,x} segment into a one-hot grid mask.
// The mask is all-zero when the lane is idle.
module snake_seg_decoder
  import snake_pkg::*;
(
  input  logic [SEG_W-1:0]      i_seg,
  input  logic                  i_en,
  output logic [GRID_CELLS-1:0] o_mask
);

  assign o_mask = i_en ? (GRID_CELLS'(1) << i_seg) : '0;

endmodule

// File: rtl/snake_grid_builder.sv
// Snapshots the snake, scans it LANES segments per cycle into a back
// bitmap, publishes to a front bitmap. Macro: SNAKE_SELF_COLLISION_EN.
module snake_grid_builder
  import snake_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int MAX_SEGS = 225,
  parameter int SNAKE_W  = 1800
)(
  input  logic               slw_clk,
  input  logic               reset,
  input  logic [SNAKE_W-1:0] snake,
  input  logic [10:0]        index,
  input  logic               write_snake,
  input  logic [3:0]         xfood,
  input  logic [3:0]         yfood,
  input  logic [3:0]         rd_x,
  input  logic [3:0]         rd_y,
  output logic [1:0]         rd_cell,
  output logic               frame_valid,
  output logic [15:0]        frame_count,
  output logic [7:0]         seg_count,
  output logic               collision
);

  localparam logic [11:0] MAXN = 12'(MAX_SEGS);

  grid_state_t r_state;
  grid_state_t w_state_nxt;

  logic [SNAKE_W-1:0]    r_snake;
  logic [7:0]            r_n;
  logic [8:0]            r_ptr;
  logic [7:0]            r_head;
  logic                  r_head_vld;
  logic [7:0]            r_food;
  logic [GRID_CELLS-1:0] r_back;
  logic [GRID_CELLS-1:0] r_front;
  logic [7:0]            r_f_head;
  logic                  r_f_head_vld;
  logic [7:0]            r_f_food;
  cell_t                 r_rd_cell;
  logic                  r_fv;
  logic [15:0]           r_fc;
  logic [7:0]            r_seg_cnt;

  logic [11:0]           w_nraw;
  logic [7:0]            w_n;
  logic [7:0]            w_head_sel;
  logic [11:0]           w_head_off;
  logic                  w_capture;
  logic                  w_publish;
  logic                  w_last;
  logic [LANES-1:0]      w_en;
  logic [7:0]            w_seg [LANES];
  logic [GRID_CELLS-1:0] w_mask [LANES];
  logic [GRID_CELLS-1:0] w_lane_mask;
  logic [7:0]            w_rd_addr;
  cell_t                 w_rd_cell;

  // Misaligned index floors to whole segments.
  assign w_nraw     = (12'(index) + 12'd1) >> 3;
  assign w_n        = (w_nraw > MAXN) ? MAXN[7:0] : w_nraw[7:0];
  assign w_head_sel = (w_n == 8'd0) ? 8'd0 : w_n - 8'd1;
  assign w_head_off = {1'b0, w_head_sel, 3'b000};

  assign w_last =
    (10'(r_ptr) + 10'(LANES) + 10'd1) >= 10'(r_n);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [9:0] w_idx;
    logic [9:0] w_sel;

    assign w_idx   = 10'(r_ptr) + 10'(i);
    assign w_en[i] = (w_idx + 10'd1) < 10'(r_n);
    assign w_sel   = w_en[i] ? w_idx : 10'd0;
    assign w_seg[i] = r_snake[{w_sel, 3'b000} +: 8];

    snake_seg_decoder u_dec (
      .i_seg  (w_seg[i]),
      .i_en   (w_en[i]),
      .o_mask (w_mask[i])
    );
  end

  always_comb begin
    w_lane_mask = '0;
    for (int i = 0; i < LANES; i++)
      w_lane_mask = w_lane_mask | w_mask[i];
  end

  always_ff @(posedge slw_clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_publish   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (write_snake) begin
          w_capture   = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        w_publish = w_last;
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge slw_clk) begin
    if (reset) begin
      r_snake      <= '0;
      r_n          <= '0;
      r_ptr        <= '0;
      r_head       <= '0;
      r_head_vld   <= 1'b0;
      r_food       <= '0;
      r_back       <= '0;
      r_front      <= '0;
      r_f_head     <= '0;
      r_f_head_vld <= 1'b0;
      r_f_food     <= '0;
      r_fv         <= 1'b0;
      r_fc         <= '0;
      r_seg_cnt    <= '0;
    end else begin
      r_fv <= w_publish;
      if (w_capture) begin
        r_snake    <= snake;
        r_n        <= w_n;
        r_head     <= snake[w_head_off +: 8];
        r_head_vld <= (w_n != 8'd0);
        r_food     <= {yfood, xfood};
        r_back     <= '0;
        r_ptr      <= '0;
      end else if (r_state == SCAN) begin
        r_back <= r_back | w_lane_mask;
        r_ptr  <= r_ptr + 9'(LANES);
      end
      if (w_publish) begin
        r_front      <= r_back | w_lane_mask;
        r_f_head     <= r_head;
        r_f_head_vld <= r_head_vld;
        r_f_food     <= r_food;
        r_fc         <= r_fc + 16'd1;
        r_seg_cnt    <= r_n;
      end
    end
  end

  // Lookup sees the front buffer as it was before this edge.
  assign w_rd_addr = {rd_y, rd_x};
  assign w_rd_cell = cell_pick(
    r_f_head_vld && (r_f_head == w_rd_addr),
    r_front[w_rd_addr],
    (r_f_food != 8'd0) && (r_f_food == w_rd_addr)
  );

  always_ff @(posedge slw_clk) begin
    if (reset) r_rd_cell <= CELL_EMPTY;
    else       r_rd_cell <= w_rd_cell;
  end

`ifdef SNAKE_SELF_COLLISION_EN
  logic [LANES-1:0] w_hit;
  logic             w_any_hit;
  logic             r_coll_acc;
  logic             r_coll;

  for (genvar i = 0; i < LANES; i++) begin : g_hit
    assign w_hit[i] = w_en[i] && (w_seg[i] == r_head);
  end
  assign w_any_hit = |w_hit;

  always_ff @(posedge slw_clk) begin
    if (reset) begin
      r_coll_acc <= 1'b0;
      r_coll     <= 1'b0;
    end else begin
      if (w_capture)
        r_coll_acc <= 1'b0;
      else if (r_state == SCAN)
        r_coll_acc <= r_coll_acc | w_any_hit;
      if (w_publish)
        r_coll <= r_coll_acc | w_any_hit;
    end
  end

  assign collision = r_coll;
`else
  assign collision = 1'b0;
`endif

  assign rd_cell     = r_rd_cell;
  assign frame_valid = r_fv;
  assign frame_count = r_fc;
  assign seg_count   = r_seg_cnt;

endmodule

// File: tb/tb_snake_grid_builder.sv
// Directed bench for snake_grid_builder (LANES=4, 225 segments).
// Collision expectations follow SNAKE_SELF_COLLISION_EN.
module tb_snake_grid_builder;
  logic          slw_clk = 1'b0;
  logic          reset;
  logic [1799:0] snake;
  logic [10:0]   index;
  logic          write_snake;
  logic [3:0]    xfood, yfood, rd_x, rd_y;
  logic [1:0]    rd_cell;
  logic          frame_valid;
  logic [15:0]   frame_count;
  logic [7:0]    seg_count;
  logic          collision;

  int tests = 0;
  int fails = 0;
  int exp_fc = 0;

`ifdef SNAKE_SELF_COLLISION_EN
  localparam logic EXP_COLL = 1'b1;
`else
  localparam logic EXP_COLL = 1'b0;
`endif

  snake_grid_builder dut (
    .slw_clk(slw_clk), .reset(reset), .snake(snake), .index(index),
    .write_snake(write_snake), .xfood(xfood), .yfood(yfood),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell),
    .frame_valid(frame_valid), .frame_count(frame_count),
    .seg_count(seg_count), .collision(collision)
  );

  always #5 slw_clk = ~slw_clk;

  task automatic tick();
    @(posedge slw_clk);
    #1;
  endtask

  task automatic set_seg(input int k, input int x, input int y);
    snake[8*k +: 8] = {4'(y), 4'(x)};
  endtask

  task automatic rd(input int x, input int y, output logic [1:0] c);
    rd_x = 4'(x);
    rd_y = 4'(y);
    tick();
    c = rd_cell;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    write_snake = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_fc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({frame_valid, frame_count, seg_count, collision, rd_cell} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got fv=%b fc=%0d sc=%0d col=%b rd=%b want all 0",
               frame_valid, frame_count, seg_count, collision, rd_cell);
    end
  endtask

  task automatic test_basic();
    logic [1:0] c;
    int xs[5] = '{1, 2, 3, 3, 0};
    int ys[5] = '{1, 1, 1, 3, 0};
    logic [1:0] ex[5] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
    snake = '0;
    set_seg(0, 1, 1); set_seg(1, 2, 1); set_seg(2, 3, 1);
    index = 11'd23; xfood = 4'd3; yfood = 4'd3;
    write_snake = 1'b1;
    tick();
    write_snake = 1'b0;
    tests++;
    if (frame_valid !== 1'b0) begin
      fails++; $display("FAIL basic_fv_e0 got %b want 0", frame_valid);
    end
    tick();
    exp_fc++;
    tests++;
    if (frame_valid !== 1'b1 || seg_count !== 8'd3 || frame_count !== 16'(exp_fc)) begin
      fails++;
      $display("FAIL basic_publish got fv=%b sc=%0d fc=%0d want 1 3 %0d",
               frame_valid, seg_count, frame_count, exp_fc);
    end
    tick();
    tests++;
    if (frame_valid !== 1'b0) begin
      fails++; $display("FAIL basic_pulse_width got %b want 0", frame_valid);
    end
    for (int i = 0; i < 5; i++) begin
      rd(xs[i], ys[i], c);
      tests++;
      if (c !== ex[i]) begin
        fails++;
        $display("FAIL basic_rd(%0d,%0d) got %b want %b", xs[i], ys[i], c, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    snake = '0;
    for (int k = 0; k < 10; k++) set_seg(k, k, 2);
    index = 11'd79; xfood = 4'd0; yfood = 4'd0;
    write_snake = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int e = 0; e < 4; e++) begin
        if (p == 2 && e == 3) write_snake = 1'b0;
        tick();
        if (e == 3) exp_fc++;
        tests++;
        if (frame_valid !== (e == 3)) begin
          fails++;
          $display("FAIL b2b_fv p%0d e%0d got %b want %b", p, e, frame_valid, e == 3);
        end
        if (e == 3) begin
          tests++;
          if (frame_count !== 16'(exp_fc) || seg_count !== 8'd10) begin
            fails++;
            $display("FAIL b2b_count p%0d got fc=%0d sc=%0d want %0d 10",
                     p, frame_count, seg_count, exp_fc);
          end
        end
      end
    end
    write_snake = 1'b0;
    tick();
  endtask

  task automatic frame4(input int y2);
    logic [1:0] c;
    snake = '0;
    set_seg(0, 5, 3); set_seg(1, 5, 4); set_seg(2, 5, y2); set_seg(3, 5, 5);
    index = 11'd31; xfood = 4'd0; yfood = 4'd0;
    write_snake = 1'b1;
    tick();
    write_snake = 1'b0;
    tick();
    exp_fc++;
    tests++;
    if (frame_valid !== 1'b1 || seg_count !== 8'd4) begin
      fails++;
      $display("FAIL coll_publish y2=%0d got fv=%b sc=%0d want 1 4", y2, frame_valid, seg_count);
    end
  endtask

  task automatic test_collision();
    logic [1:0] c;
    frame4(5);
    tests++;
    if (collision !== EXP_COLL) begin
      fails++; $display("FAIL coll_dup got %b want %b", collision, EXP_COLL);
    end
    rd(5, 5, c);
    tests++;
    if (c !== 2'b10) begin
      fails++; $display("FAIL coll_head_prio got %b want 10", c);
    end
    frame4(6);
    tests++;
    if (collision !== 1'b0) begin
      fails++; $display("FAIL coll_clear got %b want 0", collision);
    end
  endtask

  task automatic test_read_on_publish();
    snake = '0;
    set_seg(0, 5, 3); set_seg(1, 5, 4); set_seg(2, 7, 7); set_seg(3, 5, 5);
    index = 11'd31;
    rd_x = 4'd7; rd_y = 4'd7;
    write_snake = 1'b1;
    tick();
    write_snake = 1'b0;
    tests++;
    if (rd_cell !== 2'b00) begin
      fails++; $display("FAIL rop_e0 got %b want 00", rd_cell);
    end
    tick();
    exp_fc++;
    tests++;
    if (frame_valid !== 1'b1 || rd_cell !== 2'b00) begin
      fails++; $display("FAIL rop_publish got fv=%b rd=%b want 1 00", frame_valid, rd_cell);
    end
    tick();
    tests++;
    if (rd_cell !== 2'b01) begin
      fails++; $display("FAIL rop_next got %b want 01", rd_cell);
    end
  endtask

  task automatic test_reset_mid_scan();
    int bad = 0;
    logic [1:0] c;
    snake = '0;
    for (int k = 0; k < 10; k++) set_seg(k, k, 9);
    index = 11'd79;
    write_snake = 1'b1;
    tick();
    write_snake = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_fc = 0;
    for (int e = 0; e < 4; e++) begin
      tick();
      tests++;
      if (frame_valid !== 1'b0 || frame_count !== 16'd0) begin
        fails++;
        $display("FAIL rms_fv e%0d got fv=%b fc=%0d want 0 0", e, frame_valid, frame_count);
      end
    end
    for (int a = 0; a < 256; a++) begin
      rd(a % 16, a / 16, c);
      if (c !== 2'b00) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL rms_grid got %0d nonempty cells want 0", bad);
    end
  endtask

  task automatic test_max_len();
    logic [1:0] c;
    int edges = 0;
    snake = '0;
    for (int k = 0; k < 225; k++) snake[8*k +: 8] = 8'(k + 1);
    index = 11'd1799; xfood = 4'd0; yfood = 4'd0;
    write_snake = 1'b1;
    tick();
    write_snake = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (frame_valid === 1'b1) begin
        edges = e;
        break;
      end
    end
    exp_fc++;
    tests++;
    if (edges != 56 || seg_count !== 8'd225) begin
      fails++;
      $display("FAIL max_latency got edges=%0d sc=%0d want 56 225", edges, seg_count);
    end
    rd(0, 0, c);
    tests++;
    if (c !== 2'b00) begin
      fails++; $display("FAIL max_no_food got %b want 00", c);
    end
    rd(1, 14, c);
    tests++;
    if (c !== 2'b10) begin
      fails++; $display("FAIL max_head got %b want 10", c);
    end
    rd(1, 0, c);
    tests++;
    if (c !== 2'b01) begin
      fails++; $display("FAIL max_tail got %b want 01", c);
    end
  endtask

  task automatic test_small_n();
    logic [1:0] c;
    snake = '0;
    set_seg(0, 1, 1); set_seg(1, 2, 1); set_seg(2, 3, 1);
    xfood = 4'd0; yfood = 4'd0;
    index = 11'd30;
    write_snake = 1'b1;
    tick();
    write_snake = 1'b0;
    tick();
    tests++;
    if (frame_valid !== 1'b1 || seg_count !== 8'd3) begin
      fails++; $display("FAIL floor_index got fv=%b sc=%0d want 1 3", frame_valid, seg_count);
    end
    index = 11'd6;
    write_snake = 1'b1;
    tick();
    write_snake = 1'b0;
    tick();
    tests++;
    if (frame_valid !== 1'b1 || seg_count !== 8'd0) begin
      fails++; $display("FAIL zero_segs got fv=%b sc=%0d want 1 0", frame_valid, seg_count);
    end
    rd(3, 1, c);
    tests++;
    if (c !== 2'b00) begin
      fails++; $display("FAIL zero_segs_rd got %b want 00", c);
    end
  endtask

  initial begin
    reset = 1'b1; write_snake = 1'b0; snake = '0; index = '0;
    xfood = '0; yfood = '0; rd_x = '0; rd_y = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_collision();
    test_read_on_publish();
    test_reset_mid_scan();
    test_max_len();
    test_small_n();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end
endmodule
